// File: rtl/regfile_pkg.sv
// Shared definitions for the multi-ported register file: size derivation,
// flat-bus slice helpers and the busy-vector popcount.
package regfile_pkg;

   // Largest address width the popcount helper is sized for.
   localparam int MAX_ADDR_SIZE = 8;
   localparam int MAX_REGS      = 2**MAX_ADDR_SIZE;

   // Number of architectural registers for a given address width.
   function automatic int regfile_size(input int addr_size);
      return 1 << addr_size;
   endfunction

   // Low bit of port 'port' on a flat bus of 'width'-bit fields.
   function automatic int slice_lo(input int port, input int width);
      return port * width;
   endfunction

   // Number of set bits; callers zero-extend their busy vector to MAX_REGS.
   function automatic int popcount(input logic [MAX_REGS-1:0] v);
      int c;
      c = 0;
      for (int i = 0; i < MAX_REGS; i++) c += int'(v[i]);
      return c;
   endfunction

endpackage

// File: rtl/regfile_fwd_mux.sv
// Per-read-port output select. With REGFILE_BYPASS_EN defined it forwards the
// highest-priority same-cycle write to the port; otherwise it is a plain
// pass-through of committed state and has no write/set inputs at all.
module regfile_fwd_mux
   import regfile_pkg::*;
#(
   parameter int ADDR_SIZE = 5,
   parameter int WORD_SIZE = 32,
   parameter int NUM_WR    = 2
) (
   input  logic [WORD_SIZE-1:0]              rd_commit,
   input  logic                              busy_commit,
`ifdef REGFILE_BYPASS_EN
   input  logic [ADDR_SIZE-1:0]              raddr,
   input  logic [NUM_WR-1:0]                 w_en,
   input  logic [NUM_WR-1:0][ADDR_SIZE-1:0]  waddr,
   input  logic [NUM_WR-1:0][WORD_SIZE-1:0]  wdata,
   input  logic                              sb_set,
   input  logic [ADDR_SIZE-1:0]              sb_addr,
`endif
   output logic [WORD_SIZE-1:0]              rdata,
   output logic                              rbusy
);

`ifdef REGFILE_BYPASS_EN
   // Later write ports override earlier ones, so the highest index wins.
   // A forwarded value is ready, unless a new producer issues to it now.
   always_comb begin
      rdata = rd_commit;
      rbusy = busy_commit;
      for (int p = 0; p < NUM_WR; p++) begin
         if (w_en[p] && (raddr != '0) && (waddr[p] == raddr)) begin
            rdata = wdata[p];
            rbusy = sb_set && (sb_addr == raddr);
         end
      end
   end
`else
   assign rdata = rd_commit;
   assign rbusy = busy_commit;
`endif

endmodule

// File: rtl/regfile_mp.sv
// Multi-ported integer register file with hardwired-zero r0 and a per-register
// busy scoreboard. Optional same-cycle forwarding: define REGFILE_BYPASS_EN.
module regfile_mp
   import regfile_pkg::*;
#(
   parameter int ADDR_SIZE = 5,
   parameter int WORD_SIZE = 32,
   parameter int NUM_RD    = 2,
   parameter int NUM_WR    = 2
) (
   input  logic                          clk,
   input  logic                          rst,
   input  logic [NUM_RD*ADDR_SIZE-1:0]   raddr,
   output logic [NUM_RD*WORD_SIZE-1:0]   rdata,
   output logic [NUM_RD-1:0]             rbusy,
   input  logic [NUM_WR-1:0]             w_en,
   input  logic [NUM_WR*ADDR_SIZE-1:0]   waddr,
   input  logic [NUM_WR*WORD_SIZE-1:0]   wdata,
   input  logic                          sb_set,
   input  logic [ADDR_SIZE-1:0]          sb_addr,
   output logic [ADDR_SIZE:0]            busy_count
);

   localparam int REGFILE_SIZE = regfile_size(ADDR_SIZE);

   logic [REGFILE_SIZE-1:0][WORD_SIZE-1:0] regs_q, regs_d;
   logic [REGFILE_SIZE-1:0]                busy_q, busy_d;
   logic [ADDR_SIZE:0]                     busy_count_q, busy_count_d;
   logic [MAX_REGS-1:0]                    busy_ext;

   // Flat write buses viewed as per-port fields.
   logic [NUM_WR-1:0][ADDR_SIZE-1:0]       waddr_a;
   logic [NUM_WR-1:0][WORD_SIZE-1:0]       wdata_a;
   assign waddr_a = waddr;
   assign wdata_a = wdata;

   // Writes and scoreboard update; loop order gives the higher port priority,
   // and the set is applied after the clears so a re-issue keeps the bit.
   always_comb begin
      regs_d = regs_q;
      busy_d = busy_q;
      for (int p = 0; p < NUM_WR; p++) begin
         if (w_en[p] && (waddr_a[p] != '0)) begin
            regs_d[waddr_a[p]] = wdata_a[p];
            busy_d[waddr_a[p]] = 1'b0;
         end
      end
      if (sb_set && (sb_addr != '0)) busy_d[sb_addr] = 1'b1;
      regs_d[0] = '0;
      busy_d[0] = 1'b0;
   end

   // Count of the busy vector that the coming edge will commit.
   always_comb begin
      busy_ext                     = '0;
      busy_ext[REGFILE_SIZE-1:0]   = busy_d;
      busy_count_d                 = (ADDR_SIZE+1)'(popcount(busy_ext));
   end

   // State registers; reset clears everything regardless of the clock.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         regs_q       <= '0;
         busy_q       <= '0;
         busy_count_q <= '0;
      end else begin
         regs_q       <= regs_d;
         busy_q       <= busy_d;
         busy_count_q <= busy_count_d;
      end
   end

   assign busy_count = busy_count_q;

   // Committed read values; r0 is always zero/not-busy since it is never written.
   logic [NUM_RD-1:0][WORD_SIZE-1:0] rd_commit;
   logic [NUM_RD-1:0]                busy_commit;
   logic [NUM_RD-1:0][WORD_SIZE-1:0] rdata_a;

   for (genvar i = 0; i < NUM_RD; i++) begin : g_rd
      assign rd_commit[i]   = regs_q[raddr[slice_lo(i, ADDR_SIZE) +: ADDR_SIZE]];
      assign busy_commit[i] = busy_q[raddr[slice_lo(i, ADDR_SIZE) +: ADDR_SIZE]];
   end

`ifdef REGFILE_BYPASS_EN
   // Nothing is forwarded while reset holds the outputs at zero.
   logic [NUM_WR-1:0] w_en_live;
   logic              sb_set_live;
   assign w_en_live   = rst ? '0 : w_en;
   assign sb_set_live = sb_set && !rst;
`endif

   regfile_fwd_mux #(
      .ADDR_SIZE (ADDR_SIZE),
      .WORD_SIZE (WORD_SIZE),
      .NUM_WR    (NUM_WR)
   ) u_fwd [NUM_RD-1:0] (
      .rd_commit   (rd_commit),
      .busy_commit (busy_commit),
`ifdef REGFILE_BYPASS_EN
      .raddr       (raddr),
      .w_en        (w_en_live),
      .waddr       (waddr_a),
      .wdata       (wdata_a),
      .sb_set      (sb_set_live),
      .sb_addr     (sb_addr),
`endif
      .rdata       (rdata_a),
      .rbusy       (rbusy)
   );

   assign rdata = rdata_a;

endmodule

// File: tb/tb_regfile_mp.sv
// Directed bench for regfile_mp: expected values are queued as each step is
// driven and popped when the corresponding output is sampled.
module tb_regfile_mp;

   localparam int AW = 5;
   localparam int WW = 32;
   localparam int NR = 2;
   localparam int NW = 2;

   logic              clk = 1'b0;
   logic              rst = 1'b1;
   logic [NR*AW-1:0]  raddr;
   logic [NR*WW-1:0]  rdata;
   logic [NR-1:0]     rbusy;
   logic [NW-1:0]     w_en;
   logic [NW*AW-1:0]  waddr;
   logic [NW*WW-1:0]  wdata;
   logic              sb_set;
   logic [AW-1:0]     sb_addr;
   logic [AW:0]       busy_count;

   regfile_mp #(.ADDR_SIZE(AW), .WORD_SIZE(WW), .NUM_RD(NR), .NUM_WR(NW)) dut (
      .clk        (clk),
      .rst        (rst),
      .raddr      (raddr),
      .rdata      (rdata),
      .rbusy      (rbusy),
      .w_en       (w_en),
      .waddr      (waddr),
      .wdata      (wdata),
      .sb_set     (sb_set),
      .sb_addr    (sb_addr),
      .busy_count (busy_count)
   );

   always #5 clk = ~clk;

   typedef struct {
      string       tag;
      logic [31:0] val;
   } exp_t;

   exp_t sb_q[$];
   int   nvec = 0;
   int   nmis = 0;

   task automatic push(input string tag, input logic [31:0] v);
      exp_t e;
      e.tag = tag;
      e.val = v;
      sb_q.push_back(e);
   endtask

   task automatic pop_chk(input logic [31:0] obs);
      exp_t e;
      nvec++;
      if (sb_q.size() == 0) begin
         nmis++;
         $error("FAIL sb_empty: observed %0h with no expected value queued", obs);
      end else begin
         e = sb_q.pop_front();
         assert (obs === e.val)
         else begin
            nmis++;
            $error("FAIL %s: observed %0h expected %0h", e.tag, obs, e.val);
         end
      end
   endtask

   task automatic idle();
      w_en    = '0;
      waddr   = '0;
      wdata   = '0;
      sb_set  = 1'b0;
      sb_addr = '0;
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   task automatic rd(input int port, input logic [AW-1:0] a);
      raddr[port*AW +: AW] = a;
   endtask

   task automatic wr(input int port, input logic [AW-1:0] a, input logic [WW-1:0] d);
      w_en[port]           = 1'b1;
      waddr[port*AW +: AW] = a;
      wdata[port*WW +: WW] = d;
   endtask

   task automatic set_busy(input logic [AW-1:0] a);
      sb_set  = 1'b1;
      sb_addr = a;
   endtask

   function automatic logic [WW-1:0] rdat(input int port);
      return rdata[port*WW +: WW];
   endfunction

   initial begin
      #100000;
      $display("FAIL timeout: simulation did not finish");
      $fatal(1);
   end

   initial begin
      idle();
      raddr = '0;

      // reset state
      step();
      step();
      rd(0, 5'd5);
      push("rst_rdata", 32'h0);
      push("rst_rbusy", 32'h0);
      push("rst_count", 32'h0);
      #1;
      pop_chk(rdat(0));
      pop_chk({31'b0, rbusy[0]});
      pop_chk({26'b0, busy_count});
      rst = 1'b0;

      // asynchronous reset mid-cycle
      wr(0, 5'd5, 32'hDEADBEEF);
      set_busy(5'd5);
      push("pre_rst_data", 32'hDEADBEEF);
      push("pre_rst_busy", 32'h1);
      push("pre_rst_count", 32'h1);
      step();
      idle();
      #1;
      pop_chk(rdat(0));
      pop_chk({31'b0, rbusy[0]});
      pop_chk({26'b0, busy_count});
      #1 rst = 1'b1;
      push("async_rst_data", 32'h0);
      push("async_rst_busy", 32'h0);
      push("async_rst_count", 32'h0);
      #1;
      pop_chk(rdat(0));
      pop_chk({31'b0, rbusy[0]});
      pop_chk({26'b0, busy_count});
      #1 rst = 1'b0;

      // r0 is hardwired zero and never busy
      wr(0, 5'd0, 32'hFFFFFFFF);
      wr(1, 5'd0, 32'hFFFFFFFF);
      set_busy(5'd0);
      rd(0, 5'd0);
      rd(1, 5'd0);
      push("r0_p0", 32'h0);
      push("r0_p1", 32'h0);
      push("r0_busy", 32'h0);
      push("r0_count", 32'h0);
      step();
      idle();
      #1;
      pop_chk(rdat(0));
      pop_chk(rdat(1));
      pop_chk({30'b0, rbusy});
      pop_chk({26'b0, busy_count});

      // same-address write conflict: port 1 wins
      wr(0, 5'd3, 32'h11);
      wr(1, 5'd3, 32'h22);
      rd(0, 5'd3);
      push("conflict_r3", 32'h22);
      step();
      idle();
      #1;
      pop_chk(rdat(0));

      // scoreboard set / set-beats-clear / clear
      set_busy(5'd7);
      rd(0, 5'd7);
      rd(1, 5'd7);
      push("sb_set_busy", 32'h1);
      push("sb_set_count", 32'h1);
      step();
      idle();
      #1;
      pop_chk({31'b0, rbusy[0]});
      pop_chk({26'b0, busy_count});

      wr(0, 5'd7, 32'h77);
      set_busy(5'd7);
      push("sb_both_busy", 32'h1);
      push("sb_both_count", 32'h1);
      push("sb_both_data", 32'h77);
      step();
      idle();
      #1;
      pop_chk({31'b0, rbusy[1]});
      pop_chk({26'b0, busy_count});
      pop_chk(rdat(1));

      wr(0, 5'd7, 32'h88);
      push("sb_clr_busy", 32'h0);
      push("sb_clr_count", 32'h0);
      step();
      idle();
      #1;
      pop_chk({31'b0, rbusy[0]});
      pop_chk({26'b0, busy_count});

      // same-cycle read of a register being written
      wr(0, 5'd9, 32'h1);
      step();
      idle();
      rd(0, 5'd9);
      wr(0, 5'd9, 32'hABCD);
`ifdef REGFILE_BYPASS_EN
      push("bypass_same_cycle", 32'hABCD);
`else
      push("bypass_same_cycle", 32'h1);
`endif
      #1;
      pop_chk(rdat(0));
      push("bypass_next_cycle", 32'hABCD);
      step();
      idle();
      #1;
      pop_chk(rdat(0));

      // fill the scoreboard: count climbs to 31 without wrapping
      for (int a = 1; a < 32; a++) begin
         set_busy(AW'(a));
         push("fill_count", 32'(a));
         step();
         pop_chk({26'b0, busy_count});
      end
      idle();
      step();
      rd(0, 5'd31);
      rd(1, 5'd0);
      push("fill_hold", 32'd31);
      push("fill_r31_busy", 32'h1);
      push("fill_r0_busy", 32'h0);
      #1;
      pop_chk({26'b0, busy_count});
      pop_chk({31'b0, rbusy[0]});
      pop_chk({31'b0, rbusy[1]});

      $display("== %0d vectors applied, %0d miscompares ==", nvec, nmis);
      $finish;
   end

endmodule
